pixel_depth_writer: RTL and testbench
=====================================

PIXEL_DEPTH_WRITER -- requirements
Module: pixel_depth_writer

Interface
REQ-001 SHALL have parameter SCREEN_W, default 64, screen width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 64, screen height in pixels; SCREEN_W*SCREEN_H SHALL be <= 65536.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  sole clock; all state changes on rising edge.
REQ-005 in_reset_n  input  1  asynchronous active-low reset.
REQ-006 in_sig_write_pixel  input  1  pixel strobe from rasterizer; one pixel per cycle, no backpressure.
REQ-007 in_pixel_x, in_pixel_y  input  16 each  pixel screen coordinates.
REQ-008 in_pixel_depth  input  2  pixel depth; 0 nearest, 3 farthest.
REQ-009 in_pixel_color  input  16  pixel color.
REQ-010 in_sig_clear  input  1  request depth and framebuffer clear.
REQ-011 in_clear_color  input  16  background color used by clear.
REQ-012 out_fb_write_en  output  1  framebuffer write strobe, one cycle per write.
REQ-013 out_fb_addr  output  16  framebuffer address, y*SCREEN_W + x.
REQ-014 out_fb_color  output  16  framebuffer write data.
REQ-015 out_clear_busy  output  1  high while clear sweep is running.
REQ-016 out_pass_count, out_discard_count  output  16 each  saturating pixel statistics.

Function
REQ-017 SHALL hold an internal depth array of SCREEN_W*SCREEN_H 2-bit entries, indexed by y*SCREEN_W + x.
REQ-018 SHALL implement two states: RUN and CLEAR.
REQ-019 In RUN, on the edge sampling in_sig_write_pixel=1, the block SHALL register x, y, depth, color and address into stage 1 with a valid bit.
REQ-020 Stage 1 SHALL be invalid and counted as a discard if x >= SCREEN_W or y >= SCREEN_H.
REQ-021 The depth test for a valid stage-1 pixel SHALL pass when its depth is <= the stored depth. The test is combinational against the array in the cycle after capture.
REQ-022 On the next edge after a pass: the array entry SHALL be written with the pixel depth, out_fb_write_en=1 with that address and color, and out_pass_count SHALL increment.
REQ-023 On a fail: nothing SHALL be written, out_fb_write_en=0, and out_discard_count SHALL increment.
REQ-024 Latency SHALL be exactly 2 cycles from the strobe-sampling edge to out_fb_write_en. Throughput SHALL be 1 pixel per cycle.
REQ-025 Back-to-back pixels to the same address SHALL see the prior pixel's updated depth, since the array write precedes the next read.
REQ-026 in_sig_clear=1 sampled in RUN SHALL capture in_clear_color, enter CLEAR, and reset the sweep counter to 0. Any stage-1 pixel SHALL be invalidated and counted as a discard.
REQ-027 If in_sig_clear and in_sig_write_pixel are both high in RUN, clear SHALL win and the pixel SHALL be discarded.
REQ-028 In CLEAR, each cycle the block SHALL:
- write 2'b11 to entry counter;
- issue one framebuffer write with addr = counter and the captured clear color;
- increment the counter.
After entry SCREEN_W*SCREEN_H-1 it SHALL return to RUN.
REQ-029 out_clear_busy SHALL be high from the edge entering CLEAR until the edge returning to RUN, covering exactly SCREEN_W*SCREEN_H cycles.
REQ-030 During CLEAR, each strobed pixel SHALL be dropped and counted as a discard. in_sig_clear SHALL be ignored.
REQ-031 Counters SHALL saturate at 16'hFFFF and SHALL NOT wrap.

Reset
REQ-032 Asserting in_reset_n=0 SHALL immediately clear the following:
- out_fb_write_en=0, out_fb_addr=0, out_fb_color=0;
- counters=0;
- stage-1 valid=0.
REQ-033 Reset SHALL force state CLEAR with counter 0 and clear color 16'h0000, so out_clear_busy=1 during and after reset. The automatic sweep SHALL start on the first edge after release.
REQ-034 Reset mid-clear or mid-pixel SHALL abandon the operation and restart the sweep from entry 0.

Verification (SCREEN_W=SCREEN_H=8)
REQ-035 Release reset -> out_clear_busy high 64 cycles; out_fb_write_en high 64 cycles with addr 0..63 and color 0; then busy=0.
REQ-036 Pixel (2,3) depth 1 color 16'hABCD -> exactly 2 cycles later: write_en=1, addr=26, color=16'hABCD; pass_count=1.
REQ-037 Consecutive pixels at (5,5): depth 2, then 3, then 0 -> writes for the 1st and 3rd only (addr 45); pass=2, discard=1.
REQ-038 Pixel (8,0) and pixel (0,9) -> no writes; discard_count=2.
REQ-039 in_sig_clear with color 16'h1234 together with a strobed pixel, plus pixels during the sweep -> all those pixels discarded; 64 writes of 16'h1234; a later depth-3 pixel passes.
REQ-040 Pulse in_reset_n low at clear cycle 20 -> outputs zero immediately; after release a full 64-entry sweep restarts at addr 0.

Source files
------------

// File: rtl/pixel_depth_writer.sv
// Pixel depth writer: a two-stage depth-test pipeline in front of a framebuffer write port.
// It has a sweep engine that resets the depth array and paints the framebuffer with a
// background colour. Reset itself starts such a sweep with colour 0.
module pixel_depth_writer #(
    parameter int unsigned SCREEN_W = 64,
    parameter int unsigned SCREEN_H = 64
) (
    input  logic        clock,
    input  logic        in_reset_n,
    input  logic        in_sig_write_pixel,
    input  logic [15:0] in_pixel_x,
    input  logic [15:0] in_pixel_y,
    input  logic [1:0]  in_pixel_depth,
    input  logic [15:0] in_pixel_color,
    input  logic        in_sig_clear,
    input  logic [15:0] in_clear_color,
    output logic        out_fb_write_en,
    output logic [15:0] out_fb_addr,
    output logic [15:0] out_fb_color,
    output logic        out_clear_busy,
    output logic [15:0] out_pass_count,
    output logic [15:0] out_discard_count
);

    localparam int unsigned NumPix = SCREEN_W * SCREEN_H;
    localparam int unsigned AddrW  = (NumPix > 1) ? $clog2(NumPix) : 1;
    localparam logic [AddrW-1:0] LastAddr = AddrW'(NumPix - 1);

    localparam logic [0:0] StRun   = 1'b0;
    localparam logic [0:0] StClear = 1'b1;

    // Control and sweep state
    logic [0:0]       state_q, state_d;
    logic [AddrW-1:0] sweep_q, sweep_d;
    logic [15:0]      clear_color_q, clear_color_d;

    // Stage 1: captured pixel awaiting its depth test
    logic             s1_valid_q, s1_valid_d;
    logic [AddrW-1:0] s1_addr_q, s1_addr_d;
    logic [1:0]       s1_depth_q, s1_depth_d;
    logic [15:0]      s1_color_q, s1_color_d;

    // Registered framebuffer port and statistics
    logic             fb_we_q, fb_we_d;
    logic [15:0]      fb_addr_q, fb_addr_d;
    logic [15:0]      fb_color_q, fb_color_d;
    logic [15:0]      pass_q, pass_d;
    logic [15:0]      discard_q, discard_d;

    // Depth storage; every entry is rewritten by the reset sweep, so it needs no reset
    logic [1:0]       depth_mem [NumPix];
    logic             mem_we;
    logic [AddrW-1:0] mem_waddr;
    logic [1:0]       mem_wdata;

    logic             pix_in_range;
    logic [AddrW-1:0] pix_addr;
    logic [1:0]       stored_depth;
    logic             depth_pass;
    logic             pass_inc;
    logic [1:0]       discard_inc;
    logic [16:0]      pass_sum;
    logic [16:0]      discard_sum;

    // Coordinate range check and linear address of the incoming pixel
    always_comb begin
        pix_in_range = ({16'b0, in_pixel_x} < SCREEN_W) && ({16'b0, in_pixel_y} < SCREEN_H);
        pix_addr     = AddrW'(in_pixel_y) * AddrW'(SCREEN_W) + AddrW'(in_pixel_x);
    end

    // Depth test of stage 1 against the array; a write on the previous edge is already visible
    always_comb begin
        stored_depth = depth_mem[s1_addr_q];
        depth_pass   = (s1_depth_q <= stored_depth);
    end

    // Next-state logic for the pipeline, the sweep and the statistics increments
    always_comb begin
        state_d       = state_q;
        sweep_d       = sweep_q;
        clear_color_d = clear_color_q;
        s1_valid_d    = 1'b0;
        s1_addr_d     = pix_addr;
        s1_depth_d    = in_pixel_depth;
        s1_color_d    = in_pixel_color;
        fb_we_d       = 1'b0;
        fb_addr_d     = fb_addr_q;
        fb_color_d    = fb_color_q;
        mem_we        = 1'b0;
        mem_waddr     = s1_addr_q;
        mem_wdata     = s1_depth_q;
        pass_inc      = 1'b0;
        discard_inc   = 2'd0;

        if (state_q == StRun) begin
            if (in_sig_clear) begin
                // Clear wins: the pending stage-1 pixel and any simultaneous strobe are dropped
                state_d       = StClear;
                sweep_d       = '0;
                clear_color_d = in_clear_color;
                if (s1_valid_q) begin
                    discard_inc = discard_inc + 2'd1;
                end
                if (in_sig_write_pixel) begin
                    discard_inc = discard_inc + 2'd1;
                end
            end else begin
                if (s1_valid_q) begin
                    if (depth_pass) begin
                        mem_we     = 1'b1;
                        fb_we_d    = 1'b1;
                        fb_addr_d  = 16'(s1_addr_q);
                        fb_color_d = s1_color_q;
                        pass_inc   = 1'b1;
                    end else begin
                        discard_inc = discard_inc + 2'd1;
                    end
                end
                if (in_sig_write_pixel) begin
                    if (pix_in_range) begin
                        s1_valid_d = 1'b1;
                    end else begin
                        discard_inc = discard_inc + 2'd1;
                    end
                end
            end
        end else begin
            // One entry per cycle: farthest depth plus background colour
            mem_we     = 1'b1;
            mem_waddr  = sweep_q;
            mem_wdata  = 2'b11;
            fb_we_d    = 1'b1;
            fb_addr_d  = 16'(sweep_q);
            fb_color_d = clear_color_q;
            if (sweep_q == LastAddr) begin
                state_d = StRun;
                sweep_d = '0;
            end else begin
                sweep_d = sweep_q + AddrW'(1);
            end
            if (in_sig_write_pixel) begin
                discard_inc = 2'd1;
            end
        end
    end

    // Saturating statistics counters
    always_comb begin
        pass_sum    = {1'b0, pass_q} + 17'(pass_inc);
        discard_sum = {1'b0, discard_q} + 17'(discard_inc);
        pass_d      = pass_sum[16] ? 16'hFFFF : pass_sum[15:0];
        discard_d   = discard_sum[16] ? 16'hFFFF : discard_sum[15:0];
    end

    // State registers; reset lands in the sweep so the array is initialised after release
    always_ff @(posedge clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q       <= StClear;
            sweep_q       <= '0;
            clear_color_q <= 16'h0000;
            s1_valid_q    <= 1'b0;
            s1_addr_q     <= '0;
            s1_depth_q    <= 2'd0;
            s1_color_q    <= 16'h0000;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= 16'h0000;
            fb_color_q    <= 16'h0000;
            pass_q        <= 16'h0000;
            discard_q     <= 16'h0000;
        end else begin
            state_q       <= state_d;
            sweep_q       <= sweep_d;
            clear_color_q <= clear_color_d;
            s1_valid_q    <= s1_valid_d;
            s1_addr_q     <= s1_addr_d;
            s1_depth_q    <= s1_depth_d;
            s1_color_q    <= s1_color_d;
            fb_we_q       <= fb_we_d;
            fb_addr_q     <= fb_addr_d;
            fb_color_q    <= fb_color_d;
            pass_q        <= pass_d;
            discard_q     <= discard_d;
        end
    end

    // Depth array write port
    always_ff @(posedge clock) begin
        if (mem_we) begin
            depth_mem[mem_waddr] <= mem_wdata;
        end
    end

    assign out_fb_write_en   = fb_we_q;
    assign out_fb_addr       = fb_addr_q;
    assign out_fb_color      = fb_color_q;
    assign out_clear_busy    = (state_q == StClear);
    assign out_pass_count    = pass_q;
    assign out_discard_count = discard_q;

endmodule

// File: tb/tb_pixel_depth_writer.sv
// Directed bench for pixel_depth_writer on an 8x8 screen.
module tb_pixel_depth_writer;

    logic        clock;
    logic        in_reset_n;
    logic        in_sig_write_pixel;
    logic [15:0] in_pixel_x;
    logic [15:0] in_pixel_y;
    logic [1:0]  in_pixel_depth;
    logic [15:0] in_pixel_color;
    logic        in_sig_clear;
    logic [15:0] in_clear_color;
    logic        out_fb_write_en;
    logic [15:0] out_fb_addr;
    logic [15:0] out_fb_color;
    logic        out_clear_busy;
    logic [15:0] out_pass_count;
    logic [15:0] out_discard_count;

    int passed = 0;
    int total  = 0;

    pixel_depth_writer #(
        .SCREEN_W(8),
        .SCREEN_H(8)
    ) dut (
        .clock             (clock),
        .in_reset_n        (in_reset_n),
        .in_sig_write_pixel(in_sig_write_pixel),
        .in_pixel_x        (in_pixel_x),
        .in_pixel_y        (in_pixel_y),
        .in_pixel_depth    (in_pixel_depth),
        .in_pixel_color    (in_pixel_color),
        .in_sig_clear      (in_sig_clear),
        .in_clear_color    (in_clear_color),
        .out_fb_write_en   (out_fb_write_en),
        .out_fb_addr       (out_fb_addr),
        .out_fb_color      (out_fb_color),
        .out_clear_busy    (out_clear_busy),
        .out_pass_count    (out_pass_count),
        .out_discard_count (out_discard_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        strobe;
        logic [15:0] x;
        logic [15:0] y;
        logic [1:0]  depth;
        logic [15:0] color;
        logic        exp_we;
        logic [15:0] exp_addr;
        logic [15:0] exp_color;
        logic [15:0] exp_pass;
        logic [15:0] exp_disc;
    } vec_t;

    localparam int NumVec = 12;
    vec_t vecs [NumVec];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_pixel(input logic s, input int x, input int y, input int d, input int c);
        in_sig_write_pixel = s;
        in_pixel_x         = 16'(x);
        in_pixel_y         = 16'(y);
        in_pixel_depth     = 2'(d);
        in_pixel_color     = 16'(c);
    endtask

    // Runs 64 sweep edges; strobes a pixel for the first n_strobe and holds a
    // stray clear request (other colour) for the first n_clr edges.
    task automatic do_sweep(input logic [15:0] col, input int n_strobe, input int n_clr);
        for (int k = 1; k <= 64; k++) begin
            set_pixel(k <= n_strobe, 0, 0, 0, 16'hEEEE);
            in_sig_clear   = (k <= n_clr);
            in_clear_color = 16'h9999;
            tick();
            check($sformatf("sweep_we[%0d]", k), 32'(out_fb_write_en), 32'd1);
            check($sformatf("sweep_addr[%0d]", k), 32'(out_fb_addr), 32'(k - 1));
            check($sformatf("sweep_color[%0d]", k), 32'(out_fb_color), 32'(col));
            check($sformatf("sweep_busy[%0d]", k), 32'(out_clear_busy), 32'(k < 64));
        end
        set_pixel(1'b0, 0, 0, 0, 0);
        in_sig_clear = 1'b0;
        tick();
        check("post_sweep_we", 32'(out_fb_write_en), 32'd0);
        check("post_sweep_busy", 32'(out_clear_busy), 32'd0);
    endtask

    initial begin
        // Outputs after each vector's edge; a strobe shows up one vector later
        vecs[0]  = '{1'b1, 16'd2, 16'd3, 2'd1, 16'hABCD, 1'b0, 16'd0,  16'h0000, 16'd0, 16'd0};
        vecs[1]  = '{1'b0, 16'd0, 16'd0, 2'd0, 16'h0000, 1'b1, 16'd26, 16'hABCD, 16'd1, 16'd0};
        vecs[2]  = '{1'b1, 16'd5, 16'd5, 2'd2, 16'h1111, 1'b0, 16'd0,  16'h0000, 16'd1, 16'd0};
        vecs[3]  = '{1'b1, 16'd5, 16'd5, 2'd3, 16'h2222, 1'b1, 16'd45, 16'h1111, 16'd2, 16'd0};
        vecs[4]  = '{1'b1, 16'd5, 16'd5, 2'd0, 16'h3333, 1'b0, 16'd0,  16'h0000, 16'd2, 16'd1};
        vecs[5]  = '{1'b0, 16'd0, 16'd0, 2'd0, 16'h0000, 1'b1, 16'd45, 16'h3333, 16'd3, 16'd1};
        vecs[6]  = '{1'b1, 16'd8, 16'd0, 2'd0, 16'h4444, 1'b0, 16'd0,  16'h0000, 16'd3, 16'd2};
        vecs[7]  = '{1'b1, 16'd0, 16'd9, 2'd0, 16'h4444, 1'b0, 16'd0,  16'h0000, 16'd3, 16'd3};
        vecs[8]  = '{1'b1, 16'd5, 16'd5, 2'd0, 16'h4444, 1'b0, 16'd0,  16'h0000, 16'd3, 16'd3};
        vecs[9]  = '{1'b1, 16'd7, 16'd7, 2'd3, 16'h5555, 1'b1, 16'd45, 16'h4444, 16'd4, 16'd3};
        vecs[10] = '{1'b0, 16'd0, 16'd0, 2'd0, 16'h0000, 1'b1, 16'd63, 16'h5555, 16'd5, 16'd3};
        vecs[11] = '{1'b0, 16'd0, 16'd0, 2'd0, 16'h0000, 1'b0, 16'd0,  16'h0000, 16'd5, 16'd3};

        in_reset_n     = 1'b0;
        in_sig_clear   = 1'b0;
        in_clear_color = 16'h0000;
        set_pixel(1'b0, 0, 0, 0, 0);
        #23;
        check("rst_we", 32'(out_fb_write_en), 32'd0);
        check("rst_addr", 32'(out_fb_addr), 32'd0);
        check("rst_color", 32'(out_fb_color), 32'd0);
        check("rst_busy", 32'(out_clear_busy), 32'd1);
        check("rst_pass", 32'(out_pass_count), 32'd0);
        check("rst_disc", 32'(out_discard_count), 32'd0);
        @(posedge clock);
        #2;
        in_reset_n = 1'b1;
        check("rst_busy_after_release", 32'(out_clear_busy), 32'd1);
        do_sweep(16'h0000, 0, 0);

        for (int i = 0; i < NumVec; i++) begin
            set_pixel(vecs[i].strobe, int'(vecs[i].x), int'(vecs[i].y), int'(vecs[i].depth),
                      int'(vecs[i].color));
            tick();
            check($sformatf("v%0d_we", i), 32'(out_fb_write_en), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                check($sformatf("v%0d_addr", i), 32'(out_fb_addr), 32'(vecs[i].exp_addr));
                check($sformatf("v%0d_color", i), 32'(out_fb_color), 32'(vecs[i].exp_color));
            end
            check($sformatf("v%0d_pass", i), 32'(out_pass_count), 32'(vecs[i].exp_pass));
            check($sformatf("v%0d_disc", i), 32'(out_discard_count), 32'(vecs[i].exp_disc));
        end

        // Clear with a pending stage-1 pixel and a simultaneous strobe
        set_pixel(1'b1, 1, 0, 0, 16'h6666);
        tick();
        set_pixel(1'b1, 1, 1, 0, 16'h7777);
        in_sig_clear   = 1'b1;
        in_clear_color = 16'h1234;
        tick();
        check("clr_entry_we", 32'(out_fb_write_en), 32'd0);
        check("clr_entry_busy", 32'(out_clear_busy), 32'd1);
        check("clr_entry_disc", 32'(out_discard_count), 32'd5);
        check("clr_entry_pass", 32'(out_pass_count), 32'd5);
        do_sweep(16'h1234, 10, 5);
        check("clr_done_disc", 32'(out_discard_count), 32'd15);
        check("clr_done_pass", 32'(out_pass_count), 32'd5);

        // Farthest depth passes against a freshly cleared entry
        set_pixel(1'b1, 4, 4, 3, 16'hBEEF);
        tick();
        set_pixel(1'b0, 0, 0, 0, 0);
        tick();
        check("post_clr_we", 32'(out_fb_write_en), 32'd1);
        check("post_clr_addr", 32'(out_fb_addr), 32'd36);
        check("post_clr_color", 32'(out_fb_color), 32'hBEEF);
        check("post_clr_pass", 32'(out_pass_count), 32'd6);

        // Reset in the middle of a sweep
        in_sig_clear   = 1'b1;
        in_clear_color = 16'h5678;
        tick();
        in_sig_clear = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("mid_addr[%0d]", k), 32'(out_fb_addr), 32'(k - 1));
        end
        #2;
        in_reset_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(out_fb_write_en), 32'd0);
        check("mid_rst_addr", 32'(out_fb_addr), 32'd0);
        check("mid_rst_color", 32'(out_fb_color), 32'd0);
        check("mid_rst_pass", 32'(out_pass_count), 32'd0);
        check("mid_rst_disc", 32'(out_discard_count), 32'd0);
        check("mid_rst_busy", 32'(out_clear_busy), 32'd1);
        tick();
        tick();
        check("mid_rst_hold_we", 32'(out_fb_write_en), 32'd0);
        in_reset_n = 1'b1;
        do_sweep(16'h0000, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
